// File: rtl/uart_tx_control_pkg.sv
// rtl/uart_tx_control_pkg.sv - shared UART frame definitions for the transmit-side framer
//
// Purpose: default header bytes, payload byte count, FSM state encoding and
//          frame helper functions shared by the UART frame logic.
// Optional feature: UART_TX_CHECKSUM_EN adds one XOR checksum byte per frame.
package uart_tx_control_pkg;

    localparam logic [7:0] HDR0_DEFAULT  = 8'h4B;
    localparam logic [7:0] HDR1_DEFAULT  = 8'h4C;
    localparam int         HEADER_BYTES  = 2;
    localparam int         PAYLOAD_BYTES = 4;

`ifdef UART_TX_CHECKSUM_EN
    localparam int CHECKSUM_BYTES = 1;
`else
    localparam int CHECKSUM_BYTES = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } tx_state_t;

    // Total bytes on the wire for one frame.
    function automatic int frame_bytes(input int send_header);
        return ((send_header != 0) ? HEADER_BYTES : 0) + PAYLOAD_BYTES + CHECKSUM_BYTES;
    endfunction

`ifdef UART_TX_CHECKSUM_EN
    // Checksum covers the payload only; the header is excluded.
    function automatic logic [7:0] payload_xor(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction
`endif

endpackage

// File: rtl/uart_tx_control.sv
// rtl/uart_tx_control.sv - frames one 32-bit word into a UART byte stream
//
// Purpose: sends optional header HDR0,HDR1 then the latched word LSB first
//          (plus an XOR checksum byte when UART_TX_CHECKSUM_EN is defined),
//          driving a byte transmitter through an enable/busy handshake.
// Ports:
//   clk_50m       in   system clock
//   rst_n         in   asynchronous active-low reset
//   tx_start      in   frame request, sampled only while tx_ready=1
//   data_in_0     in   [31:0] word, captured in the accept cycle
//   tx_ready      out  1 = idle, next tx_start accepted
//   uart_tx_busy  in   byte transmitter busy
//   uart_tx_en    out  1-cycle load pulse for uart_tx_data
//   uart_tx_data  out  [7:0] byte to transmit, held until next uart_tx_en
//   tx_done       out  1-cycle pulse after the last byte's busy falls
// Optional feature macro: UART_TX_CHECKSUM_EN
module uart_tx_control
    import uart_tx_control_pkg::*;
#(
    parameter logic [7:0] HDR0        = HDR0_DEFAULT,
    parameter logic [7:0] HDR1        = HDR1_DEFAULT,
    parameter int         SEND_HEADER = 1,
    parameter int         BYTE_GAP    = 0
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [31:0] data_in_0,
    output logic        tx_ready,
    input  logic        uart_tx_busy,
    output logic        uart_tx_en,
    output logic [7:0]  uart_tx_data,
    output logic        tx_done
);

    localparam logic [2:0] LAST_IDX = 3'(frame_bytes(SEND_HEADER) - 1);
    localparam logic [2:0] HDR_SKIP = (SEND_HEADER != 0) ? 3'd2 : 3'd0;
    localparam bit         GAP_EN   = (BYTE_GAP > 0);
    // Only meaningful when GAP_EN; wraps harmlessly otherwise.
    localparam logic [7:0] GAP_LAST = 8'(BYTE_GAP - 1);

    tx_state_t   state, state_nx;
    logic [2:0]  idx, idx_nx;
    logic [7:0]  gap_cnt, gap_nx;
    logic [31:0] word_q, word_nx;
    logic        en_q, en_nx;
    logic [7:0]  data_q, data_nx;

    logic [2:0]  pidx;
    logic [7:0]  cur_byte;
    logic        advance;

    // Byte select: header slots first, then payload index relative to header.
    always_comb begin
        pidx     = idx - HDR_SKIP;
        cur_byte = 8'h00;
        if ((SEND_HEADER != 0) && (idx == 3'd0)) begin
            cur_byte = HDR0;
        end else if ((SEND_HEADER != 0) && (idx == 3'd1)) begin
            cur_byte = HDR1;
        end else begin
            case (pidx)
                3'd0:    cur_byte = word_q[7:0];
                3'd1:    cur_byte = word_q[15:8];
                3'd2:    cur_byte = word_q[23:16];
                3'd3:    cur_byte = word_q[31:24];
`ifdef UART_TX_CHECKSUM_EN
                3'd4:    cur_byte = payload_xor(word_q);
`endif
                default: cur_byte = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        gap_nx   = gap_cnt;
        word_nx  = word_q;
        en_nx    = 1'b0;
        data_nx  = data_q;
        advance  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    word_nx  = data_in_0;
                    idx_nx   = 3'd0;
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!uart_tx_busy) begin
                    en_nx    = 1'b1;
                    data_nx  = cur_byte;
                    state_nx = ST_GUARD;
                end
            end
            // Transmitter has not raised busy yet; do not trust it this cycle.
            ST_GUARD: begin
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (!uart_tx_busy) begin
                    if (GAP_EN) begin
                        gap_nx   = 8'd0;
                        state_nx = ST_GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    gap_nx = gap_cnt + 8'd1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Next-byte decision folded into the WAIT/GAP exit cycle.
        if (advance) begin
            if (idx == LAST_IDX) begin
                state_nx = ST_DONE;
            end else begin
                idx_nx   = idx + 3'd1;
                state_nx = ST_SEND;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= 3'd0;
            gap_cnt <= 8'd0;
            word_q  <= 32'h0;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            gap_cnt <= gap_nx;
            word_q  <= word_nx;
            en_q    <= en_nx;
            data_q  <= data_nx;
        end
    end

    assign tx_ready     = (state == ST_IDLE);
    assign tx_done      = (state == ST_DONE);
    assign uart_tx_en   = en_q;
    assign uart_tx_data = data_q;

endmodule

// File: tb/tb_uart_tx_control.sv
// tb/tb_uart_tx_control.sv - scoreboard bench for uart_tx_control
module tb_uart_tx_control;

    localparam int BUSY_LEN = 10;
    localparam int GAP_B    = 20;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n = 1'b0;

    logic        tx_start_a = 1'b0;
    logic [31:0] data_in_a  = 32'h0;
    logic        tx_ready_a, busy_a, en_a, done_a;
    logic [7:0]  data_a;
    logic        hold_busy_a = 1'b0;
    int          busy_cnt_a  = 0;

    logic        tx_start_b = 1'b0;
    logic [31:0] data_in_b  = 32'h0;
    logic        tx_ready_b, busy_b, en_b, done_b;
    logic [7:0]  data_b;
    int          busy_cnt_b = 0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int en_cnt_a    = 0;
    int done_cnt_a  = 0;
    int done_cnt_b  = 0;
    int idle_run_b  = 0;
    int frame_pos_b = 0;

    uart_tx_control #(.HDR0(8'h4B), .HDR1(8'h4C), .SEND_HEADER(1), .BYTE_GAP(0)) dut_a (
        .clk_50m(clk), .rst_n(rst_n), .tx_start(tx_start_a), .data_in_0(data_in_a),
        .tx_ready(tx_ready_a), .uart_tx_busy(busy_a), .uart_tx_en(en_a),
        .uart_tx_data(data_a), .tx_done(done_a)
    );

    uart_tx_control #(.HDR0(8'h4B), .HDR1(8'h4C), .SEND_HEADER(0), .BYTE_GAP(GAP_B)) dut_b (
        .clk_50m(clk), .rst_n(rst_n), .tx_start(tx_start_b), .data_in_0(data_in_b),
        .tx_ready(tx_ready_b), .uart_tx_busy(busy_b), .uart_tx_en(en_b),
        .uart_tx_data(data_b), .tx_done(done_b)
    );

    // Byte transmitter models: busy rises the cycle after a load, lasts BUSY_LEN cycles.
    always @(posedge clk) begin
        if (en_a) busy_cnt_a <= BUSY_LEN;
        else if (busy_cnt_a > 0) busy_cnt_a <= busy_cnt_a - 1;
        if (en_b) busy_cnt_b <= BUSY_LEN;
        else if (busy_cnt_b > 0) busy_cnt_b <= busy_cnt_b - 1;
    end
    assign busy_a = hold_busy_a || (busy_cnt_a != 0);
    assign busy_b = (busy_cnt_b != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input bit hdr, input logic [31:0] w, inout logic [7:0] q[$]);
        if (hdr) begin
            q.push_back(8'h4B);
            q.push_back(8'h4C);
        end
        q.push_back(w[7:0]);
        q.push_back(w[15:8]);
        q.push_back(w[23:16]);
        q.push_back(w[31:24]);
`ifdef UART_TX_CHECKSUM_EN
        q.push_back(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
    endtask

    // Scoreboard monitors: compare every load pulse against the expected queue.
    always @(negedge clk) begin
        logic [7:0] e;
        if (en_a) begin
            en_cnt_a++;
            if (exp_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_byte: got %02h expected none", data_a);
            end else begin
                e = exp_a.pop_front();
                check("a_byte", {24'h0, data_a}, {24'h0, e});
            end
        end
        if (done_a) begin
            done_cnt_a++;
            check("a_done_after_last_byte", exp_a.size(), 0);
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (en_b) begin
            if (frame_pos_b != 0) check("b_gap_ge_20", {31'h0, idle_run_b >= GAP_B}, 1);
            frame_pos_b++;
            idle_run_b = 0;
            if (exp_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_byte: got %02h expected none", data_b);
            end else begin
                e = exp_b.pop_front();
                check("b_byte", {24'h0, data_b}, {24'h0, e});
            end
        end else if (!busy_b) begin
            idle_run_b++;
        end
        if (done_b) begin
            done_cnt_b++;
            frame_pos_b = 0;
            check("b_done_after_last_byte", exp_b.size(), 0);
        end
    end

    task automatic start_a(input logic [31:0] w);
        @(negedge clk);
        check("a_ready_before_start", tx_ready_a, 1);
        data_in_a  = w;
        tx_start_a = 1'b1;
        @(negedge clk);
        tx_start_a = 1'b0;
        data_in_a  = 32'hFFFF_FFFF;
    endtask

    task automatic wait_done_a(input int bound, input bit poke);
        bit seen = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (done_a) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL a_done_timeout: got no tx_done expected one within %0d cycles", bound);
        end else begin
            if (poke) begin
                tx_start_a = 1'b1;
                data_in_a  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            tx_start_a = 1'b0;
            check("a_ready_after_done", tx_ready_a, 1);
            check("a_done_single_cycle", done_a, 0);
        end
    endtask

    initial begin
        int snap_en;
        int snap_done;
        bit seen;

        #1;
        check("reset_ready", tx_ready_a, 1);
        check("reset_en", en_a, 0);
        check("reset_data", data_a, 0);
        check("reset_done", done_a, 0);
        check("reset_b_ready", tx_ready_b, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, latency of first load pulse.
        push_frame(1'b1, 32'h1234_5678, exp_a);
        start_a(32'h1234_5678);
        check("t1_en_low_t1", en_a, 0);
        check("t1_ready_low", tx_ready_a, 0);
        @(negedge clk);
        check("t1_en_high_t2", en_a, 1);
        check("t1_first_byte", data_a, 8'h4B);
        wait_done_a(2000, 1'b0);
        check("t1_done_count", done_cnt_a, 1);

        // Busy held high before the first byte.
        hold_busy_a = 1'b1;
        push_frame(1'b1, 32'h1234_5678, exp_a);
        snap_en = en_cnt_a;
        start_a(32'h1234_5678);
        repeat (500) @(negedge clk);
        check("t2_no_en_while_busy", en_cnt_a, snap_en);
        check("t2_ready_low_while_busy", tx_ready_a, 0);
        hold_busy_a = 1'b0;
        wait_done_a(2000, 1'b0);
        check("t2_done_count", done_cnt_a, 2);

        // tx_start mid-frame and in the DONE cycle is ignored.
        push_frame(1'b1, 32'h1234_5678, exp_a);
        start_a(32'h1234_5678);
        repeat (30) @(negedge clk);
        data_in_a  = 32'hDEAD_BEEF;
        tx_start_a = 1'b1;
        @(negedge clk);
        tx_start_a = 1'b0;
        wait_done_a(2000, 1'b1);
        repeat (100) @(negedge clk);
        check("t3_done_count", done_cnt_a, 3);
        check("t3_ready_idle", tx_ready_a, 1);

        // Reset after the third byte aborts the frame.
        push_frame(1'b1, 32'h1234_5678, exp_a);
        snap_en = en_cnt_a;
        start_a(32'h1234_5678);
        seen = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (en_cnt_a >= snap_en + 3) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_third_byte_seen", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_ready", tx_ready_a, 1);
        check("t4_rst_en", en_a, 0);
        check("t4_rst_data", data_a, 0);
        check("t4_rst_done", done_a, 0);
        exp_a.delete();
        snap_done = done_cnt_a;
        snap_en   = en_cnt_a;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("t4_no_done_after_abort", done_cnt_a, snap_done);
        check("t4_no_en_after_abort", en_cnt_a, snap_en);
        push_frame(1'b1, 32'h1234_5678, exp_a);
        start_a(32'h1234_5678);
        wait_done_a(2000, 1'b0);
        check("t4_fresh_done_count", done_cnt_a, snap_done + 1);

        // Payload-only frame with inter-byte gap.
        push_frame(1'b0, 32'hA5A5_0F0F, exp_b);
        @(negedge clk);
        check("t6_b_ready", tx_ready_b, 1);
        data_in_b  = 32'hA5A5_0F0F;
        tx_start_b = 1'b1;
        @(negedge clk);
        tx_start_b = 1'b0;
        data_in_b  = 32'h0;
        seen = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (done_cnt_b == 1) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_b_done_seen", seen, 1);
        @(negedge clk);
        check("t6_b_ready_after", tx_ready_b, 1);
        repeat (50) @(negedge clk);

        check("end_a_queue_empty", exp_a.size(), 0);
        check("end_b_queue_empty", exp_b.size(), 0);
        check("end_b_done_count", done_cnt_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
